serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single instance of the team's `full_adder` cell (ports Sout, Cout, A, B, Cin).
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Computes one bit per clock, LSB first, with the carry held in a flop between cycles.
- Returns the WIDTH-bit sum and the carry-out over a second valid/ready handshake.
- Sits downstream of operand sources and drives the `full_adder` cell directly. It is the sequential wrapper the testbench uses to check the adder cell over many cycles.

---
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, carry held in a flop.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow output ovf.

module full_adder (
  output logic Sout,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);
  assign Sout = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] resultNext;
  logic             carry;
  logic [CW-1:0]    count;
  logic             faSum;
  logic             faCout;

  full_adder fa (
    .Sout(faSum),
    .Cout(faCout),
    .A   (opA[0]),
    .B   (opB[0]),
    .Cin (carry)
  );

  // New sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
  assign resultNext = (result >> 1) | (WIDTH'(faSum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      opA       <= '0;
      opB       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      count     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opA      <= a;
            opB      <= b;
            carry    <= cin;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          opA    <= opA >> 1;
          opB    <= opB >> 1;
          carry  <= faCout;
          result <= resultNext;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            sum       <= resultNext;
            cout      <= faCout;
`ifdef SERIAL_ADDER_OVF_EN
            // On the final bit the carry flop holds the carry into the MSB.
            ovf       <= carry ^ faCout;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
// against a plain-arithmetic reference model.

module tb_serial_adder;
  logic       clk;
  logic       rst;
  logic       inValid, inReady, outValid, outReady, cin, cout;
  logic [7:0] a, b, sum;
  logic       inValid1, inReady1, outValid1, outReady1, cin1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf1;
`endif
  int         testCount = 0;
  int         failCount = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .cin(cin), .out_valid(outValid), .out_ready(outReady),
    .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(outValid1), .out_ready(outReady1),
    .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One WIDTH=8 operation; inputs are scrambled during RUN to show they are ignored.
  task automatic applyStimulus(input logic [7:0] opa, input logic [7:0] opb, input logic ci, input int hold);
    logic [8:0] full;
    logic [7:0] expSum;
    logic       expCout, expOvf;
    int         lat;
    full    = {1'b0, opa} + {1'b0, opb} + {8'b0, ci};
    expSum  = full[7:0];
    expCout = full[8];
    expOvf  = (opa[7] == opb[7]) && (expSum[7] != opa[7]);
    @(negedge clk);
    checkOutput("in_ready_idle", inReady, 1);
    inValid = 1'b1; a = opa; b = opb; cin = ci;
    @(posedge clk);
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!outValid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    inValid = 1'b0;
    checkOutput("latency", lat, 8);
    checkOutput("sum", sum, expSum);
    checkOutput("cout", cout, expCout);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("ovf", ovf, expOvf);
`else
    if (expOvf) begin end
`endif
    for (int k = 0; k < hold; k++) begin
      checkOutput("in_ready_busy", inReady, 0);
      @(negedge clk);
      checkOutput("hold_valid", outValid, 1);
      checkOutput("hold_sum", sum, expSum);
      checkOutput("hold_cout", cout, expCout);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("in_ready_after", inReady, 1);
    checkOutput("out_valid_drop", outValid, 0);
  endtask

  task automatic applyStimulus1(input logic opa, input logic opb, input logic ci);
    logic [1:0] full;
    int         lat;
    full = {1'b0, opa} + {1'b0, opb} + {1'b0, ci};
    @(negedge clk);
    inValid1 = 1'b1; a1 = opa; b1 = opb; cin1 = ci;
    @(posedge clk);
    @(negedge clk);
    inValid1 = 1'b0;
    lat = 0;
    while (!outValid1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w1_latency", lat, 1);
    checkOutput("w1_sum", sum1, full[0]);
    checkOutput("w1_cout", cout1, full[1]);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("w1_ovf", ovf1, ci ^ full[1]);
`endif
    outReady1 = 1'b1;
    @(negedge clk);
    outReady1 = 1'b0;
    checkOutput("w1_in_ready_after", inReady1, 1);
  endtask

  task automatic checkResetAbort();
    bit seen;
    @(negedge clk);
    inValid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready", inReady, 1);
    checkOutput("abort_out_valid", outValid, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_cout", cout, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (outValid) seen = 1'b1;
    end
    checkOutput("abort_no_result", seen, 0);
  endtask

  initial begin
    rst = 1'b1;
    inValid = 1'b0; outReady = 1'b0; a = '0; b = '0; cin = 1'b0;
    inValid1 = 1'b0; outReady1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", inReady, 1);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    checkOutput("reset_w1_in_ready", inReady1, 1);
    rst = 1'b0;

    applyStimulus(8'h3C, 8'h05, 1'b0, 0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 0);
    applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 5);
    checkResetAbort();
    for (int i = 0; i < 20; i++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    for (int i = 0; i < 8; i++) begin
      logic [2:0] combo;
      combo = 3'(i);
      applyStimulus1(combo[2], combo[1], combo[0]);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
